// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
// Module : branch_resolve_unit_pkg
// Brief  : Condition codes and helpers shared by the branch resolve unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

    localparam int BRU_CTRL_W = 4;

    typedef logic [BRU_CTRL_W-1:0] bru_ctrl_t;

    localparam bru_ctrl_t BRU_EQ  = 4'd0;
    localparam bru_ctrl_t BRU_NE  = 4'd1;
    localparam bru_ctrl_t BRU_GT  = 4'd2;
    localparam bru_ctrl_t BRU_LT  = 4'd3;
    localparam bru_ctrl_t BRU_GE  = 4'd4;
    localparam bru_ctrl_t BRU_LE  = 4'd5;
    localparam bru_ctrl_t BRU_EQZ = 4'd6;
    localparam bru_ctrl_t BRU_NEZ = 4'd7;
    localparam bru_ctrl_t BRU_GTZ = 4'd8;
    localparam bru_ctrl_t BRU_LTZ = 4'd9;
    localparam bru_ctrl_t BRU_GEZ = 4'd10;
    localparam bru_ctrl_t BRU_LEZ = 4'd11;

    // Codes at or above this bound are undefined.
    localparam bru_ctrl_t BRU_CTRL_UNDEF = 4'd12;

    function automatic logic bru_is_zero_form(input bru_ctrl_t c);
        return (c >= BRU_EQZ) && (c <= BRU_LEZ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// Module : branch_resolve_unit_if
// Brief  : Op/record handshake bundle; stats signals exist only with BRU_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    bru_ctrl_t         ctrl;
    logic              is_signed;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic              pred_taken;
    logic [ADDR_W-1:0] target_pc;
    logic [ADDR_W-1:0] fall_pc;
    logic              out_valid;
    logic              out_ready;
    logic              taken;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic              bad_ctrl;
`ifdef BRU_STATS_EN
    logic              stat_clr;
    logic [31:0]       stat_branches;
    logic [31:0]       stat_taken;
    logic [31:0]       stat_mispred;

    modport slave (
        input  flush, in_valid, ctrl, is_signed, rs1, rs2, pred_taken,
               target_pc, fall_pc, out_ready, stat_clr,
        output in_ready, out_valid, taken, mispredict, redirect_pc, bad_ctrl,
               stat_branches, stat_taken, stat_mispred
    );
    modport master (
        output flush, in_valid, ctrl, is_signed, rs1, rs2, pred_taken,
               target_pc, fall_pc, out_ready, stat_clr,
        input  in_ready, out_valid, taken, mispredict, redirect_pc, bad_ctrl,
               stat_branches, stat_taken, stat_mispred
    );
`else
    modport slave (
        input  flush, in_valid, ctrl, is_signed, rs1, rs2, pred_taken,
               target_pc, fall_pc, out_ready,
        output in_ready, out_valid, taken, mispredict, redirect_pc, bad_ctrl
    );
    modport master (
        output flush, in_valid, ctrl, is_signed, rs1, rs2, pred_taken,
               target_pc, fall_pc, out_ready,
        input  in_ready, out_valid, taken, mispredict, redirect_pc, bad_ctrl
    );
`endif
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit_compare.sv
// ============================================================================
// Module : bru_compare
// Brief  : Combinational branch condition evaluator (signed/unsigned, *Z forms).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bru_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  bru_ctrl_t         ctrl_i,
    input  logic              is_signed_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output logic              cond_o,
    output logic              bad_o
);

    logic [DATA_W-1:0] w_rhs;
    logic              w_eq;
    logic              w_lt;

    // The *Z forms share the two-operand datapath with a zero right-hand side.
    assign w_rhs = bru_is_zero_form(ctrl_i) ? '0 : rs2_i;
    assign w_eq  = (rs1_i == w_rhs);
    assign w_lt  = is_signed_i ? ($signed(rs1_i) < $signed(w_rhs)) : (rs1_i < w_rhs);

    always_comb begin
        cond_o = 1'b0;
        bad_o  = 1'b0;
        case (ctrl_i)
            BRU_EQ,  BRU_EQZ: cond_o = w_eq;
            BRU_NE,  BRU_NEZ: cond_o = !w_eq;
            BRU_GT,  BRU_GTZ: cond_o = !w_lt && !w_eq;
            BRU_LT,  BRU_LTZ: cond_o = w_lt;
            BRU_GE,  BRU_GEZ: cond_o = !w_lt;
            BRU_LE,  BRU_LEZ: cond_o = w_lt || w_eq;
            default:          bad_o  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Registered branch resolution with valid/ready, stall and flush.
//          Optional counters under macro BRU_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);

    logic              w_cond;
    logic              w_bad;
    logic              w_accept;
    logic              w_mispredict;

    logic              out_valid_q,   out_valid_d;
    logic              taken_q,       taken_d;
    logic              mispredict_q,  mispredict_d;
    logic              bad_ctrl_q,    bad_ctrl_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    bru_compare #(
        .DATA_W (DATA_W)
    ) u_compare (
        .ctrl_i      (bus.ctrl),
        .is_signed_i (bus.is_signed),
        .rs1_i       (bus.rs1),
        .rs2_i       (bus.rs2),
        .cond_o      (w_cond),
        .bad_o       (w_bad)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_mispredict = (w_cond != bus.pred_taken);

    always_comb begin
        out_valid_d   = out_valid_q;
        taken_d       = taken_q;
        mispredict_d  = mispredict_q;
        bad_ctrl_d    = bad_ctrl_q;
        redirect_pc_d = redirect_pc_q;
        // Flush only drops valid; stale data is harmless behind out_valid=0.
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d   = 1'b1;
            taken_d       = w_cond;
            mispredict_d  = w_mispredict;
            bad_ctrl_d    = w_bad;
            redirect_pc_d = w_cond ? bus.target_pc : bus.fall_pc;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            taken_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            bad_ctrl_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            taken_q       <= taken_d;
            mispredict_q  <= mispredict_d;
            bad_ctrl_q    <= bad_ctrl_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.taken       = taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.bad_ctrl    = bad_ctrl_q;
    assign bus.redirect_pc = redirect_pc_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_taken_q;
    logic [31:0] stat_mispred_q;

    // Counts every accept, including ops a same-cycle flush squashes.
    always_ff @(posedge clk) begin
        if (rst || bus.stat_clr) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
            stat_mispred_q  <= '0;
        end else if (w_accept) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            stat_taken_q    <= stat_taken_q + {31'd0, w_cond};
            stat_mispred_q  <= stat_mispred_q + {31'd0, w_mispredict};
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_taken    = stat_taken_q;
    assign bus.stat_mispred  = stat_mispred_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module : tb_branch_resolve_unit
// Brief  : Directed and randomized checks against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    branch_resolve_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the visible record
    bit          m_valid, m_taken, m_misp, m_bad;
    logic [31:0] m_pc;
    int unsigned m_sb, m_st, m_sm;
    bit          pre_ready_exp;
    logic        pre_ready_dut;

    function automatic bit ref_taken(input logic [3:0] c, input logic s,
                                     input logic [31:0] a, input logic [31:0] b);
        longint va, vb;
        if (c >= 4'd12) return 1'b0;
        va = s ? longint'($signed(a)) : longint'(a);
        vb = (c >= 4'd6) ? 64'sd0 : (s ? longint'($signed(b)) : longint'(b));
        case (c % 4'd6)
            4'd0:    return va == vb;
            4'd1:    return va != vb;
            4'd2:    return va >  vb;
            4'd3:    return va <  vb;
            4'd4:    return va >= vb;
            default: return va <= vb;
        endcase
    endfunction

    task automatic set_op(input logic [3:0] c, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic p,
                          input logic [31:0] tgt, input logic [31:0] fall);
        bus.in_valid   = 1'b1;
        bus.ctrl       = c;
        bus.is_signed  = s;
        bus.rs1        = a;
        bus.rs2        = b;
        bus.pred_taken = p;
        bus.target_pc  = tgt;
        bus.fall_pc    = fall;
    endtask

    // Advances one clock, updating the model from the inputs currently driven.
    task automatic step();
        bit acc, t;
        #1;
        pre_ready_dut = bus.in_ready;
        pre_ready_exp = !m_valid || bus.out_ready;
        acc = bus.in_valid && pre_ready_exp;
        t   = ref_taken(bus.ctrl, bus.is_signed, bus.rs1, bus.rs2);
        if (rst) begin
            m_valid = 0; m_taken = 0; m_misp = 0; m_bad = 0; m_pc = '0;
            m_sb = 0; m_st = 0; m_sm = 0;
        end else begin
            if (bus.flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_taken = t; m_misp = (t != bus.pred_taken);
                m_bad = (bus.ctrl >= 4'd12); m_pc = t ? bus.target_pc : bus.fall_pc;
            end else if (m_valid && bus.out_ready) m_valid = 0;
`ifdef BRU_STATS_EN
            if (bus.stat_clr) begin
                m_sb = 0; m_st = 0; m_sm = 0;
            end else if (acc) begin
                m_sb++; m_st += int'(t); m_sm += int'(t != bus.pred_taken);
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_op(BRU_EQ, 1'b0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h44);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got=%b exp=0", i, bus.out_valid);
            else n_pass++;
        end
        n_checks++;
        if (bus.taken !== 1'b0 || bus.redirect_pc !== 32'h0)
            $display("FAIL reset_data taken=%b pc=%h exp 0/0", bus.taken, bus.redirect_pc);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.taken !== 1'b1 || bus.redirect_pc !== 32'h100)
            $display("FAIL reset_first_op v=%b t=%b pc=%h exp 1/1/00000100",
                     bus.out_valid, bus.taken, bus.redirect_pc);
        else n_pass++;
    endtask

    task automatic test_signedness();
        logic [3:0]  c  [4] = '{BRU_LT, BRU_LT, BRU_LTZ, BRU_LTZ};
        logic        s  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic        ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(c[i], s[i], a[i], 32'd1, 1'b0, 32'h200, 32'h204);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.taken !== ex[i] || m_taken != ex[i])
                $display("FAIL sign_case%0d v=%b taken=%b model=%b exp=%b",
                         i, bus.out_valid, bus.taken, m_taken, ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mispredict();
        bus.out_ready = 1'b1;
        set_op(BRU_EQ, 1'b0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h44);
        step();
        n_checks++;
        if (bus.taken !== 1'b1 || bus.mispredict !== 1'b1 || bus.redirect_pc !== 32'h100)
            $display("FAIL misp_eq t=%b m=%b pc=%h exp 1/1/00000100",
                     bus.taken, bus.mispredict, bus.redirect_pc);
        else n_pass++;
        set_op(BRU_NE, 1'b0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h44);
        step();
        n_checks++;
        if (bus.taken !== 1'b0 || bus.mispredict !== 1'b0 || bus.redirect_pc !== 32'h44)
            $display("FAIL misp_ne t=%b m=%b pc=%h exp 0/0/00000044",
                     bus.taken, bus.mispredict, bus.redirect_pc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] held_pc;
        logic        held_t;
        bus.out_ready = 1'b1;
        set_op(BRU_GT, 1'b1, 32'd9, 32'd3, 1'b1, 32'h300, 32'h304);
        step();
        held_pc = bus.redirect_pc;
        held_t  = bus.taken;
        bus.out_ready = 1'b0;
        set_op(BRU_LT, 1'b1, 32'd9, 32'd3, 1'b0, 32'h400, 32'h404);
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (pre_ready_dut !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.redirect_pc !== held_pc || bus.taken !== held_t || held_pc !== 32'h300)
                $display("FAIL stall_hold cyc%0d rdy=%b v=%b pc=%h t=%b exp 0/1/00000300/1",
                         i, pre_ready_dut, bus.out_valid, bus.redirect_pc, bus.taken);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(BRU_EQ, 1'b0, 32'(i), 32'(i % 2), 1'b0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
            step();
            n_checks++;
            if (pre_ready_dut !== 1'b1 || bus.out_valid !== 1'b1 ||
                bus.redirect_pc !== m_pc || bus.taken !== m_taken)
                $display("FAIL b2b op%0d rdy=%b v=%b pc=%h exp_pc=%h t=%b exp_t=%b",
                         i, pre_ready_dut, bus.out_valid, bus.redirect_pc, m_pc, bus.taken, m_taken);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        set_op(BRU_NEZ, 1'b0, 32'd7, 32'd0, 1'b1, 32'h500, 32'h504);
        step();
        bus.out_ready = 1'b0;
        step();
        bus.flush = 1'b1;
        set_op(BRU_EQZ, 1'b0, 32'd0, 32'd0, 1'b0, 32'h600, 32'h604);
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_drop v=%b exp=0", bus.out_valid);
        else n_pass++;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_no_emit v=%b exp=0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_bad_ctrl();
        bus.out_ready = 1'b1;
        set_op(4'd13, 1'b1, 32'd1, 32'd1, 1'b1, 32'h700, 32'h704);
        step();
        n_checks++;
        if (bus.bad_ctrl !== 1'b1 || bus.taken !== 1'b0 || bus.mispredict !== 1'b1 ||
            bus.redirect_pc !== 32'h704)
            $display("FAIL bad_ctrl bad=%b t=%b m=%b pc=%h exp 1/0/1/00000704",
                     bus.bad_ctrl, bus.taken, bus.mispredict, bus.redirect_pc);
        else n_pass++;
    endtask

`ifdef BRU_STATS_EN
    task automatic test_stats();
        rst = 1'b1; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.stat_clr = 1'b0;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_op(i < 6 ? BRU_EQ : BRU_NE, 1'b0, 32'd3, 32'd3,
                   (i == 0) ? 1'b0 : ((i == 6) ? 1'b1 : (i < 6)), 32'h800, 32'h804);
            step();
        end
        n_checks++;
        if (bus.stat_branches !== 32'd10 || bus.stat_taken !== 32'd6 || bus.stat_mispred !== 32'd2)
            $display("FAIL stats_count got=%0d/%0d/%0d exp=10/6/2",
                     bus.stat_branches, bus.stat_taken, bus.stat_mispred);
        else n_pass++;
        bus.stat_clr = 1'b1;
        step();
        bus.stat_clr = 1'b0;
        n_checks++;
        if (bus.stat_branches !== 32'd0 || bus.stat_taken !== 32'd0 || bus.stat_mispred !== 32'd0)
            $display("FAIL stats_clr got=%0d/%0d/%0d exp=0/0/0",
                     bus.stat_branches, bus.stat_taken, bus.stat_mispred);
        else n_pass++;
    endtask
`endif

    function automatic logic [31:0] rand_operand();
        case ($urandom % 4)
            0:       return $urandom;
            1:       return 32'h0;
            2:       return 32'h8000_0000;
            default: return 32'($urandom % 4);
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a;
        int          errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            a = rand_operand();
            set_op(4'($urandom_range(0, 15)), 1'($urandom % 2), a,
                   (($urandom % 10) < 3) ? a : rand_operand(), 1'($urandom % 2), $urandom, $urandom);
            bus.in_valid  = (($urandom % 10) < 7);
            bus.out_ready = (($urandom % 4) != 0);
            bus.flush     = (($urandom % 20) == 0);
            rst           = (($urandom % 100) == 0);
`ifdef BRU_STATS_EN
            bus.stat_clr  = (($urandom % 40) == 0);
`endif
            step();
            n_checks++;
            if (pre_ready_dut !== pre_ready_exp || bus.out_valid !== m_valid ||
                (m_valid && (bus.taken !== m_taken || bus.mispredict !== m_misp ||
                             bus.bad_ctrl !== m_bad || bus.redirect_pc !== m_pc))) begin
                errs++;
                if (errs < 10)
                    $display("FAIL rand cyc%0d rdy=%b/%b v=%b/%b t=%b/%b m=%b/%b b=%b/%b pc=%h/%h",
                             i, pre_ready_dut, pre_ready_exp, bus.out_valid, m_valid, bus.taken, m_taken,
                             bus.mispredict, m_misp, bus.bad_ctrl, m_bad, bus.redirect_pc, m_pc);
            end else n_pass++;
`ifdef BRU_STATS_EN
            n_checks++;
            if (bus.stat_branches !== m_sb || bus.stat_taken !== m_st || bus.stat_mispred !== m_sm)
                $display("FAIL rand_stats cyc%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                         bus.stat_branches, bus.stat_taken, bus.stat_mispred, m_sb, m_st, m_sm);
            else n_pass++;
`endif
        end
        rst = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.ctrl = '0; bus.is_signed = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
        bus.pred_taken = 1'b0; bus.target_pc = '0; bus.fall_pc = '0;
`ifdef BRU_STATS_EN
        bus.stat_clr = 1'b0;
`endif
        m_valid = 0; m_taken = 0; m_misp = 0; m_bad = 0; m_pc = '0;
        m_sb = 0; m_st = 0; m_sm = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_signedness();
        test_mispredict();
        test_back_to_back();
        test_flush();
        test_bad_ctrl();
`ifdef BRU_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch-compare logic in the EX stage.
- Evaluates the branch condition with configurable operand width and signed/unsigned mode, and compares the outcome with the fetch-stage prediction.
- Produces a registered resolution record (taken, mispredict, redirect PC) under a valid/ready handshake for the PC-select/hazard logic.
- Supports stall and pipeline flush.

Parameters:
DATA_W, 32, operand width in bits
ADDR_W, 32, PC width in bits

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
flush  in  1  kill held/incoming resolution (younger-than-redirect squash)
in_valid  in  1  branch op present
in_ready  out  1  unit can accept op this cycle
ctrl  in  4  condition code (see Behaviour)
is_signed  in  1  1 = two's-complement compare, 0 = unsigned
rs1  in  DATA_W  first operand
rs2  in  DATA_W  second operand (ignored by *Z codes)
pred_taken  in  1  fetch-stage prediction
target_pc  in  ADDR_W  branch target
fall_pc  in  ADDR_W  PC+4 of branch
out_valid  out  1  resolution record valid
out_ready  in  1  consumer accepts record
taken  out  1  resolved direction
mispredict  out  1  taken != pred_taken
redirect_pc  out  ADDR_W  target_pc if taken else fall_pc
bad_ctrl  out  1  ctrl was an undefined code

Behaviour:
- ctrl codes: 0 EQ, 1 NE, 2 GT, 3 LT, 4 GE, 5 LE, 6 EQZ, 7 NEZ, 8 GTZ, 9 LTZ, 10 GEZ, 11 LEZ. The *Z codes compare rs1 with 0.
- Codes 12-15 are undefined: taken=0, bad_ctrl=1; mispredict is still computed.
- Ordering comparisons (GT..LE, GTZ..LEZ):
  - is_signed=1: two's-complement, so LTZ is true iff rs1[DATA_W-1]=1.
  - is_signed=0: unsigned, so LTZ is never taken and GEZ is always taken.
- EQ, NE, EQZ and NEZ ignore is_signed.
- Single output register, latency 1: an op accepted at edge N is visible on the outputs after edge N.
- in_ready = !out_valid || out_ready (combinational; supports full throughput).
- Accept = in_valid && in_ready.
- Each edge, highest priority first:
  1. rst: out_valid=0, taken=0, mispredict=0, bad_ctrl=0, redirect_pc=0.
  2. flush: out_valid=0. The record is discarded even if in_valid=1 or the consumer was handshaking this cycle.
  3. accept: load the record, out_valid=1.
  4. out_valid && out_ready with no accept: out_valid=0.
  5. Otherwise hold all outputs stable.
- While out_valid=1 && out_ready=0, outputs must not change.
- Data outputs need not be cleared when out_valid falls; consumers qualify them with out_valid.
- Reset mid-stall drops the held record. The first op is accepted on the cycle after rst deasserts.
- Flush and accept in the same cycle: the op is lost; upstream treats it as squashed.

Optional Feature:
- Macro BRU_STATS_EN.
- When defined, adds outputs stat_branches, stat_taken and stat_mispred (32 bits each) and input stat_clr.
  - Counters increment on each accept, counted on the accepting edge, flush-independent.
  - stat_taken and stat_mispred increment when the accepted op resolves taken/mispredicted.
  - Counters wrap at 2^32.
  - Cleared by rst or stat_clr; stat_clr wins over a same-cycle increment.
- When undefined: no counter ports or logic; behaviour otherwise identical.

Decomposition:
- Shared defines header holds:
  - ctrl code constants (BRU_EQ..BRU_LEZ);
  - BRU_CTRL_W=4;
  - the undefined-code range bound (12).
- One natural sub-module: bru_compare, purely combinational, parametrised DATA_W. Inputs ctrl, is_signed, rs1, rs2; outputs cond and bad.
- The top level holds the handshake register, flush priority and optional stats.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, taken=0, redirect_pc=0; after release, first op is visible one cycle later.
- Signedness: LT with rs1=0xFFFFFFFF, rs2=1 -> signed: taken=1; unsigned: taken=0. LTZ with rs1=0x80000000 -> signed: taken=1; unsigned: taken=0.
- Mispredict and redirect: EQ, rs1=rs2=5, pred_taken=0, target_pc=0x100, fall_pc=0x44 -> taken=1, mispredict=1, redirect_pc=0x100. NE on the same operands with pred_taken=0 -> mispredict=0, redirect_pc=0x44.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and outputs frozen. Raise out_ready -> back-to-back ops at one per cycle.
- Flush: assert flush with in_valid=1 and a stalled record -> next cycle out_valid=0, no record emitted.
- Bad code and stats: ctrl=13 -> bad_ctrl=1, taken=0. With BRU_STATS_EN, 10 ops (6 taken, 2 mispredicted) -> counters 10/6/2; stat_clr -> 0/0/0.
